// File: rtl/rbcla_pipe_adder.sv
// Pipelined ripple-block carry look-ahead adder: BLK-bit CLA blocks, BLKS_PER_STAGE
// blocks per stage, add/subtract, carry-in and a valid/ready handshake with global stall.
module rbcla_pipe_adder #(
  parameter int WIDTH          = 19,
  parameter int BLK            = 4,
  parameter int BLKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s
);
  localparam int NBLK = (WIDTH + BLK - 1) / BLK;
  localparam int NSTG = (NBLK + BLKS_PER_STAGE - 1) / BLKS_PER_STAGE;
  localparam int SB   = BLK * BLKS_PER_STAGE;

  logic adv_s;
  assign adv_s    = ~out_valid | out_ready;
  assign in_ready = adv_s;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    // LO/HI bound the bits this stage resolves; RW is the operand width still unresolved.
    localparam int LO = k * SB;
    localparam int HI = ((k + 1) * SB < WIDTH) ? (k + 1) * SB : WIDTH;
    localparam int RW = WIDTH - LO;
    localparam int SW = HI - LO;

    logic [RW-1:0]             xi_s, yi_s;
    logic                      subi_s, ci_s, vi_s;
    logic [HI-1:0]             sumn_s;
    logic [SW-1:0]             g_s, p_s, c_s, ssum_s;
    logic [BLKS_PER_STAGE-1:0] bg_s, bp_s;
    logic [BLKS_PER_STAGE:0]   bc_s;
    logic                      t_s;
    logic                      v_r, c_r;
    logic [HI-1:0]             sum_r;

    if (k == 0) begin : g_in
      assign xi_s   = x;
      assign yi_s   = y;
      assign subi_s = sub;
      assign ci_s   = cin | sub;
      assign vi_s   = in_valid;
      assign sumn_s = ssum_s;
    end else begin : g_in
      assign xi_s   = g_stg[k-1].g_fwd.x_r;
      assign yi_s   = g_stg[k-1].g_fwd.y_r;
      assign subi_s = g_stg[k-1].g_fwd.sub_r;
      assign ci_s   = g_stg[k-1].c_r;
      assign vi_s   = g_stg[k-1].v_r;
      assign sumn_s = {ssum_s, g_stg[k-1].sum_r};
    end

    // Stage look-ahead: bit g/p, block G/P, block carries, then in-block carries and sums.
    always_comb begin
      g_s    = '0;
      p_s    = '0;
      c_s    = '0;
      ssum_s = '0;
      bg_s   = '0;
      bp_s   = '1;
      bc_s   = '0;
      t_s    = 1'b0;
      for (int i = 0; i < SW; i++) begin
        g_s[i] = xi_s[i] & (yi_s[i] ^ subi_s);
        p_s[i] = xi_s[i] ^ (yi_s[i] ^ subi_s);
      end
      // Padding blocks past the top bit keep G=0/P=1 so they pass the carry through.
      for (int j = 0; j < BLKS_PER_STAGE; j++) begin
        for (int i = j * BLK; i < (((j + 1) * BLK < SW) ? (j + 1) * BLK : SW); i++) begin
          bg_s[j] = g_s[i] | (p_s[i] & bg_s[j]);
          bp_s[j] = bp_s[j] & p_s[i];
        end
      end
      bc_s[0] = ci_s;
      for (int j = 1; j <= BLKS_PER_STAGE; j++) begin
        bc_s[j] = ci_s;
        for (int i = 0; i < j; i++) bc_s[j] = bc_s[j] & bp_s[i];
        for (int i = 0; i < j; i++) begin
          t_s = bg_s[i];
          for (int m = i + 1; m < j; m++) t_s = t_s & bp_s[m];
          bc_s[j] = bc_s[j] | t_s;
        end
      end
      for (int i = 0; i < SW; i++) begin
        c_s[i] = bc_s[i / BLK];
        for (int q = (i / BLK) * BLK; q < i; q++) c_s[i] = c_s[i] & p_s[q];
        for (int q = (i / BLK) * BLK; q < i; q++) begin
          t_s = g_s[q];
          for (int m = q + 1; m < i; m++) t_s = t_s & p_s[m];
          c_s[i] = c_s[i] | t_s;
        end
        ssum_s[i] = p_s[i] ^ c_s[i];
      end
    end

    // Stage valid, outgoing carry and accumulated sum bits; all hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= '0;
      end else if (adv_s) begin
        v_r   <= vi_s;
        c_r   <= bc_s[BLKS_PER_STAGE];
        sum_r <= sumn_s;
      end
    end

    if (k < NSTG - 1) begin : g_fwd
      logic [WIDTH-HI-1:0] x_r, y_r;
      logic                sub_r;
      // Operand bits for the stages that have not been resolved yet.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_r   <= '0;
          y_r   <= '0;
          sub_r <= 1'b0;
        end else if (adv_s) begin
          x_r   <= xi_s[RW-1:SW];
          y_r   <= yi_s[RW-1:SW];
          sub_r <= subi_s;
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].v_r;
  assign s         = {g_stg[NSTG-1].c_r, g_stg[NSTG-1].sum_r};
endmodule

// File: tb/tb_rbcla_pipe_adder.sv
// Scoreboard bench for rbcla_pipe_adder: directed vectors on the default build plus
// random streams on a parameter sweep, each checked for value and latency.
module tb_rbcla_pipe_adder;
  localparam int W    = 19;
  localparam int NSTG = 3;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [W-1:0] x, y;
  logic [W:0]   s;
  int           checks = 0, errors = 0, cyc = 0;
  logic [W:0]   exp_q[$];
  int           lat_q[$], acc_q[$];
  logic         held_f = 1'b0;
  logic [W:0]   held_s, m_e;
  int           m_l, m_a;
  logic         sw_rst_n, sw_ord;

  assign sw_ord = 1'b1;

  rbcla_pipe_adder #(.WIDTH(W), .BLK(4), .BLKS_PER_STAGE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: stall behaviour while held, scoreboard pop on every transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && !out_ready) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
      end
      if (held_f) begin
        checks++;
        if (s !== held_s) begin
          errors++; $display("FAIL held_s_stable: got %h want %h", s, held_s);
        end
      end
      held_f = 1'b1; held_s = s;
    end else begin
      held_f = 1'b0;
    end
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_out: got s=%h with empty scoreboard", s);
      end else begin
        m_e = exp_q.pop_front(); m_l = lat_q.pop_front(); m_a = acc_q.pop_front();
        if (s !== m_e) begin
          errors++; $display("FAIL result: got %h want %h", s, m_e);
        end
        if (m_l >= 0) begin
          checks++;
          if (cyc - m_a != m_l) begin
            errors++; $display("FAIL latency: got %0d want %0d", cyc - m_a, m_l);
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sb, input logic [W:0] e, input int lat, output int waited);
    waited = 0;
    in_valid = 1'b1; x = a; y = b; cin = ci; sub = sb;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk); waited++;
    end
    if (!in_ready) begin
      checks++; errors++; $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
    end else begin
      exp_q.push_back(e); lat_q.push_back(lat); acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain_timeout: %0d left want 0", exp_q.size());
      exp_q.delete(); lat_q.delete(); acc_q.delete();
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_valid: got %b want 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int w, n;
    logic [31:0] r1, r2, r3;
    logic [W-1:0] a, b;
    logic [W:0]   e;
    rst_n = 1'b0; sw_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 20'h00000) begin
      errors++; $display("FAIL reset_state: in_ready=%b out_valid=%b s=%h want 1 0 00000", in_ready, out_valid, s);
    end
    @(negedge clk); rst_n = 1'b1; sw_rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add crossing every block boundary.
    send(19'h7FFFF, 19'h00001, 1'b0, 1'b0, 20'h80000, NSTG, w);
    in_valid = 1'b0;
    drain();

    // Full carry chain, then subtract with and without borrow.
    send(19'h7FFFF, 19'h7FFFF, 1'b1, 1'b0, 20'h0FFFFF, NSTG, w);
    send(19'h00005, 19'h00007, 1'b1, 1'b1, 20'h7FFFE, NSTG, w);
    send(19'h00007, 19'h00005, 1'b0, 1'b1, 20'h80002, NSTG, w);
    in_valid = 1'b0;
    drain();

    // Back-to-back random stream, one result per cycle.
    for (int i = 0; i < 100; i++) begin
      r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
      a = r1[W-1:0]; b = r2[W-1:0];
      e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, r3[0]};
      send(a, b, r3[0], 1'b0, e, NSTG, w);
      checks++;
      if (w != 0) begin
        errors++; $display("FAIL stream_in_ready: waited %0d want 0", w);
      end
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: out_ready low for 5 cycles starting 2 cycles into the burst.
    fork
      begin
        int wb;
        send(19'h00001, 19'h00002, 1'b0, 1'b0, 20'h00003, -1, wb);
        send(19'h40000, 19'h40000, 1'b1, 1'b0, 20'h80001, -1, wb);
        send(19'h00010, 19'h00003, 1'b0, 1'b1, 20'h8000D, -1, wb);
        send(19'h00000, 19'h00000, 1'b1, 1'b0, 20'h00001, -1, wb);
        in_valid = 1'b0;
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two beats in flight.
    send(19'h00005, 19'h00006, 1'b0, 1'b0, 20'h0000B, NSTG, w);
    send(19'h00008, 19'h00009, 1'b0, 1'b0, 20'h00011, NSTG, w);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || s !== 20'h00000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_midop: out_valid=%b s=%h in_ready=%b want 0 00000 1", out_valid, s, in_ready);
    end
    exp_q.delete(); lat_q.delete(); acc_q.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(19'h00001, 19'h00001, 1'b0, 1'b0, 20'h00002, NSTG, w);
    in_valid = 1'b0;
    drain();

    n = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && n < 5000) begin
      @(posedge clk); n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++; $display("FAIL sweep_timeout: sweep still running after %0d cycles", n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  localparam int SW_W [4] = '{8, 19, 32, 5};
  localparam int SW_B [4] = '{4, 3, 4, 4};
  localparam int SW_P [4] = '{1, 2, 8, 1};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int CW  = SW_W[gi];
    localparam int CB  = SW_B[gi];
    localparam int CP  = SW_P[gi];
    localparam int CNS = (((CW + CB - 1) / CB) + CP - 1) / CP;
    logic          iv, ir, ci, sb, ov;
    logic          done = 1'b0;
    logic [CW-1:0] a, b, bb;
    logic [CW:0]   so, e, me;
    logic [CW:0]   q[$];
    int            qa[$];
    int            ma;

    rbcla_pipe_adder #(.WIDTH(CW), .BLK(CB), .BLKS_PER_STAGE(CP)) u_dut (
      .clk(clk), .rst_n(sw_rst_n), .in_valid(iv), .in_ready(ir),
      .x(a), .y(b), .cin(ci), .sub(sb),
      .out_valid(ov), .out_ready(sw_ord), .s(so)
    );

    initial begin
      logic [31:0] r1, r2, r3;
      iv = 1'b0; a = '0; b = '0; ci = 1'b0; sb = 1'b0;
      wait (sw_rst_n === 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 250; i++) begin
        r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
        a = r1[CW-1:0]; b = r2[CW-1:0]; ci = r3[0]; sb = r3[1];
        bb = sb ? ~b : b;
        e = {1'b0, a} + {1'b0, bb} + {{CW{1'b0}}, (sb | ci)};
        iv = 1'b1;
        @(negedge clk);
        checks++;
        if (ir !== 1'b1) begin
          errors++; $display("FAIL sweep%0d_in_ready: got %b want 1", gi, ir);
        end else begin
          q.push_back(e); qa.push_back(cyc);
        end
        @(posedge clk); #1;
      end
      iv = 1'b0;
      repeat (CNS + 3) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
        errors++; $display("FAIL sweep%0d_leftover: %0d left want 0", gi, q.size());
      end
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (sw_rst_n && ov) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL sweep%0d_unexpected: got s=%h", gi, so);
        end else begin
          me = q.pop_front(); ma = qa.pop_front();
          if (so !== me) begin
            errors++; $display("FAIL sweep%0d_result: got %h want %h", gi, so, me);
          end
          checks++;
          if (cyc - ma != CNS) begin
            errors++; $display("FAIL sweep%0d_latency: got %0d want %0d", gi, cyc - ma, CNS);
          end
        end
      end
    end
  end
endmodule

// File: doc/rbcla_pipe_adder.md
Name: rbcla_pipe_adder

Overview:
- Parametrised, pipelined successor of the 19-bit ripple-block carry look-ahead adder.
- Operands are split into BLK-bit CLA blocks. Each pipeline stage resolves BLKS_PER_STAGE blocks and registers the inter-block carry.
- Adds an add/subtract mode, a carry-in and a valid/ready stream handshake with full-pipeline stall.
- Sits in the arithmetic datapath as the general-purpose two-operand adder.

Parameters:
- WIDTH, 19, operand width in bits (>=2).
- BLK, 4, bits per CLA block; the last block is WIDTH mod BLK bits when that is nonzero.
- BLKS_PER_STAGE, 2, CLA blocks resolved per pipeline stage (>=1).
- Derived: NBLK = ceil(WIDTH/BLK); NSTG = ceil(NBLK/BLKS_PER_STAGE). Defaults give NBLK=5, NSTG=3.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  adder accepts a beat this cycle.
- x  in  WIDTH  operand X, unsigned.
- y  in  WIDTH  operand Y, unsigned.
- cin  in  1  carry-in (add mode only).
- sub  in  1  0: S=X+Y+cin; 1: S=X+~Y+1, cin ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- s  out  WIDTH+1  result; s[WIDTH] is the carry-out (in sub mode, 1 means no borrow).

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits, out_valid, s and all pipeline registers clear to 0. in_ready is 1 during and after reset.
- Handshake:
  - adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - A beat is accepted when in_valid & in_ready.
  - When adv=0 every stage holds (global stall). A held output does not change.
- Pipeline:
  - Stage 0 registers the stage-0 results, the outgoing carry, and the raw x, y, sub for the remaining bits.
  - Stage k (1..NSTG-1) resolves its blocks from the carry registered by stage k-1, then registers its sum bits.
  - Lower sum bits already computed travel down the pipeline unchanged.
  - Stage NSTG-1 output is s, with the final carry written to s[WIDTH].
  - Latency: NSTG cycles from acceptance to out_valid with no stall. Throughput: 1 beat/cycle.
- Block arithmetic:
  - Per bit: g = a & b', p = a ^ b', where b' = y ^ {WIDTH{sub}}.
  - Per block: internal carries by look-ahead from the block carry-in; block G/P as in a standard CLA unit.
  - Blocks inside one stage chain by look-ahead on block G/P. The stage carry-in is cin|sub for stage 0, otherwise the registered carry.
- Short last block: a WIDTH not divisible by BLK gives a narrow top block; its G/P covers only its real bits. A last stage with fewer than BLKS_PER_STAGE blocks is legal.
- Bubbles: a stage valid bit of 0 propagates as a bubble; data registers may hold stale values while valid=0.
- Simultaneous accept and drain on the same edge is legal and must not drop or duplicate beats.
- Reset mid-operation discards every in-flight beat. No output appears after reset until new beats are accepted.
- NSTG=1 (BLKS_PER_STAGE>=NBLK): a single registered stage, latency 1.

Test Plan:
1. Default params, add: x=0x7FFFF, y=0x00001, cin=0, sub=0 → s=0x080000 exactly 3 cycles after accept; out_valid high for 1 cycle with out_ready=1.
2. Full carry chain: x=0x7FFFF, y=0x7FFFF, cin=1 → s=0x0FFFFF. Then sub=1, x=0x00005, y=0x00007 → s=0x07FFFE with s[19]=0 (borrow). Then sub=1, x=7, y=5 → s=0x080002.
3. Back-to-back streaming: 100 random beats, in_valid=1 continuously, out_ready=1 → results in order, one per cycle, each matching a reference x+y+cin; in_ready never drops.
4. Backpressure: send 4 beats while out_ready is held 0 for 5 cycles from cycle 2 → in_ready=0 whenever out_valid=1 and out_ready=0; s holds stable; all 4 results emerge in order after release with no loss or duplication.
5. Reset mid-operation: assert rst_n=0 asynchronously with 2 beats in flight → out_valid=0 and s=0 immediately; after release, no stale results. A new beat 1+1 yields s=2 after 3 cycles.
6. Parameter sweep: (WIDTH, BLK, BLKS_PER_STAGE) = (8,4,1), (19,3,2), (32,4,8), (5,4,1) → latency equals NSTG in each case; 1000 random add and sub vectors match the reference model.
